// File: rtl/reg_bank8_if.sv
// Bus bundle for reg_bank8: write port, two read ports and stack-pointer controls.
interface reg_bank8_if;
  logic       wr_en;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic [2:0] rd_sel_a;
  logic [2:0] rd_sel_b;
  logic [7:0] rd_a;
  logic [7:0] rd_b;
  logic       sp_inc;
  logic       sp_dec;
  logic [7:0] sp;
  logic       sp_err;

  // Master drives requests and observes read data and stack-pointer status.
  modport master (
    output wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b, sp_inc, sp_dec,
    input  rd_a, rd_b, sp, sp_err
  );

  // Slave is the register bank itself.
  modport slave (
    input  wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b, sp_inc, sp_dec,
    output rd_a, rd_b, sp, sp_err
  );
endinterface

// File: rtl/reg_bank8.sv
// reg_bank8: eight 8-bit registers r0-r7 with one write port, two combinational
// read ports with write-first bypass, and r7 acting as a stack pointer with
// increment/decrement and a sticky wrap error flag.

// Generic 8-way selector feeding each read port.
module mux_8way #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  input  logic [W-1:0] f,
  input  logic [W-1:0] g,
  input  logic [W-1:0] h,
  input  logic [2:0]   sel,
  output logic [W-1:0] y
);
  // Pick one of eight inputs by index.
  always_comb begin
    y = a;
    case (sel)
      3'd0: y = a;
      3'd1: y = b;
      3'd2: y = c;
      3'd3: y = d;
      3'd4: y = e;
      3'd5: y = f;
      3'd6: y = g;
      3'd7: y = h;
      default: y = a;
    endcase
  end
endmodule

// Generic 2-way selector used for the write-first bypass.
module mux_2way #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

module reg_bank8 #(
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_bank8_if.slave  bus
);
  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic       sp_err_q;
  logic       sp_err_d;

  logic [7:0] mux_a;
  logic [7:0] mux_b;
  logic       byp_a;
  logic       byp_b;
  logic       wr_sp;

  // A write to r7 takes priority over any stack-pointer inc/dec.
  assign wr_sp = bus.wr_en && (bus.wr_sel == 3'd7);

  // Next-state: apply the write port, then the stack-pointer update unless r7 is being written.
  always_comb begin
    regs_d   = regs_q;
    sp_err_d = sp_err_q;
    if (bus.wr_en) begin
      regs_d[bus.wr_sel] = bus.wr_data;
    end
    if (!wr_sp) begin
      case ({bus.sp_inc, bus.sp_dec})
        2'b10: begin
          regs_d[7] = regs_q[7] + 8'd1;
          if (regs_q[7] == 8'hFF) sp_err_d = 1'b1;
        end
        2'b01: begin
          regs_d[7] = regs_q[7] - 8'd1;
          if (regs_q[7] == 8'h00) sp_err_d = 1'b1;
        end
        default: ; // none, or both cancel out
      endcase
    end
  end

  // Register state with asynchronous clear; r7 restarts at SP_RESET.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) regs_q[i] <= 8'h00;
      regs_q[7] <= SP_RESET;
      sp_err_q  <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      sp_err_q <= sp_err_d;
    end
  end

  // Bypass compare runs beside the 8-way select; suppressed while in reset.
  assign byp_a = rst_n && bus.wr_en && (bus.wr_sel == bus.rd_sel_a);
  assign byp_b = rst_n && bus.wr_en && (bus.wr_sel == bus.rd_sel_b);

  mux_8way #(.W(8)) u_mux_a (
    .a(regs_q[0]), .b(regs_q[1]), .c(regs_q[2]), .d(regs_q[3]),
    .e(regs_q[4]), .f(regs_q[5]), .g(regs_q[6]), .h(regs_q[7]),
    .sel(bus.rd_sel_a), .y(mux_a)
  );

  mux_8way #(.W(8)) u_mux_b (
    .a(regs_q[0]), .b(regs_q[1]), .c(regs_q[2]), .d(regs_q[3]),
    .e(regs_q[4]), .f(regs_q[5]), .g(regs_q[6]), .h(regs_q[7]),
    .sel(bus.rd_sel_b), .y(mux_b)
  );

  mux_2way #(.W(8)) u_byp_a (.a(mux_a), .b(bus.wr_data), .sel(byp_a), .y(bus.rd_a));
  mux_2way #(.W(8)) u_byp_b (.a(mux_b), .b(bus.wr_data), .sel(byp_b), .y(bus.rd_b));

  // Stack pointer view is the raw register, never bypassed.
  assign bus.sp     = regs_q[7];
  assign bus.sp_err = sp_err_q;
endmodule

// File: tb/tb_reg_bank8.sv
// Directed self-checking bench for reg_bank8.
module tb_reg_bank8;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  reg_bank8_if bus ();

  reg_bank8 #(.SP_RESET(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_sel = 3'd0; bus.wr_data = 8'h00;
    bus.sp_inc = 1'b0; bus.sp_dec = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.wr_en = 1'b1; bus.wr_sel = 3'd3; bus.wr_data = 8'h5A;
    bus.rd_sel_b = 3'd7;
    step(); step();
    for (int s = 0; s < 7; s++) begin
      bus.rd_sel_a = s[2:0];
      #1;
      total_cnt++;
      if (bus.rd_a !== 8'h00) $display("FAIL reset_r%0d: got %h want 00", s, bus.rd_a);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.rd_b !== 8'hFF) $display("FAIL reset_rd_b_r7: got %h want FF", bus.rd_b);
    else pass_cnt++;
    total_cnt++;
    if (bus.sp !== 8'hFF) $display("FAIL reset_sp: got %h want FF", bus.sp);
    else pass_cnt++;
    total_cnt++;
    if (bus.sp_err !== 1'b0) $display("FAIL reset_sp_err: got %b want 0", bus.sp_err);
    else pass_cnt++;
    idle();
    #1 rst_n = 1'b1;
    step();
    bus.rd_sel_a = 3'd3;
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'h00) $display("FAIL reset_r3_after: got %h want 00", bus.rd_a);
    else pass_cnt++;
  endtask

  task automatic test_write_read_all();
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1; bus.wr_sel = i[2:0]; bus.wr_data = 8'(10 * (i + 1));
      step();
    end
    idle();
    for (int s = 0; s < 8; s++) begin
      bus.rd_sel_a = s[2:0];
      bus.rd_sel_b = 3'(7 - s);
      #1;
      total_cnt++;
      if (bus.rd_a !== 8'(10 + 10 * s)) $display("FAIL wr_all_rd_a sel%0d: got %0d want %0d", s, bus.rd_a, 10 + 10 * s);
      else pass_cnt++;
      total_cnt++;
      if (bus.rd_b !== 8'(80 - 10 * s)) $display("FAIL wr_all_rd_b sel%0d: got %0d want %0d", s, bus.rd_b, 80 - 10 * s);
      else pass_cnt++;
    end
  endtask

  task automatic test_bypass();
    bus.wr_en = 1'b1; bus.wr_sel = 3'd2; bus.wr_data = 8'h11;
    step();
    idle();
    bus.rd_sel_a = 3'd2; bus.rd_sel_b = 3'd5;
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'h11) $display("FAIL byp_pre_r2: got %h want 11", bus.rd_a);
    else pass_cnt++;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd2; bus.wr_data = 8'hC3;
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'hC3) $display("FAIL byp_same_cycle: got %h want C3", bus.rd_a);
    else pass_cnt++;
    total_cnt++;
    if (bus.rd_b !== 8'd60) $display("FAIL byp_other_port: got %h want 3C", bus.rd_b);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'hC3) $display("FAIL byp_after_edge: got %h want C3", bus.rd_a);
    else pass_cnt++;
  endtask

  task automatic test_sp_wrap();
    do_reset();
    bus.sp_inc = 1'b1;
    step();
    idle();
    total_cnt++;
    if (bus.sp !== 8'h00) $display("FAIL wrap_inc_sp: got %h want 00", bus.sp);
    else pass_cnt++;
    total_cnt++;
    if (bus.sp_err !== 1'b1) $display("FAIL wrap_inc_err: got %b want 1", bus.sp_err);
    else pass_cnt++;
    bus.sp_dec = 1'b1;
    step(); step();
    idle();
    total_cnt++;
    if (bus.sp !== 8'hFE) $display("FAIL wrap_dec_sp: got %h want FE", bus.sp);
    else pass_cnt++;
    total_cnt++;
    if (bus.sp_err !== 1'b1) $display("FAIL wrap_dec_err: got %b want 1", bus.sp_err);
    else pass_cnt++;
    bus.rd_sel_a = 3'd7;
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'hFE) $display("FAIL wrap_rd_r7: got %h want FE", bus.rd_a);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.wr_en = 1'b1; bus.wr_sel = 3'd7; bus.wr_data = 8'h40;
    step();
    idle();
    bus.sp_inc = 1'b1; bus.sp_dec = 1'b1;
    step();
    idle();
    total_cnt++;
    if (bus.sp !== 8'h40) $display("FAIL sim_incdec_sp: got %h want 40", bus.sp);
    else pass_cnt++;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd7; bus.wr_data = 8'h00; bus.sp_dec = 1'b1;
    step();
    idle();
    total_cnt++;
    if (bus.sp !== 8'h00) $display("FAIL sim_wr_dec_sp: got %h want 00", bus.sp);
    else pass_cnt++;
    total_cnt++;
    if (bus.sp_err !== 1'b0) $display("FAIL sim_wr_dec_err: got %b want 0", bus.sp_err);
    else pass_cnt++;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd4; bus.wr_data = 8'h77; bus.sp_inc = 1'b1;
    bus.rd_sel_a = 3'd7; bus.rd_sel_b = 3'd3;
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'h00) $display("FAIL sim_inc_no_bypass: got %h want 00", bus.rd_a);
    else pass_cnt++;
    step();
    idle();
    bus.rd_sel_a = 3'd4;
    #1;
    total_cnt++;
    if (bus.sp !== 8'h01) $display("FAIL sim_wr4_inc_sp: got %h want 01", bus.sp);
    else pass_cnt++;
    total_cnt++;
    if (bus.rd_a !== 8'h77) $display("FAIL sim_wr4_inc_r4: got %h want 77", bus.rd_a);
    else pass_cnt++;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd7; bus.wr_data = 8'hFF;
    step();
    bus.wr_data = 8'h10; bus.sp_inc = 1'b1;
    step();
    idle();
    total_cnt++;
    if (bus.sp !== 8'h10) $display("FAIL sim_wr_beats_wrap_sp: got %h want 10", bus.sp);
    else pass_cnt++;
    total_cnt++;
    if (bus.sp_err !== 1'b0) $display("FAIL sim_wr_beats_wrap_err: got %b want 0", bus.sp_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.wr_en = 1'b1; bus.wr_sel = 3'd1; bus.wr_data = 8'hAA;
    step();
    bus.wr_sel = 3'd6; bus.wr_data = 8'hBB;
    step();
    bus.wr_sel = 3'd7; bus.wr_data = 8'h00;
    step();
    idle();
    bus.sp_dec = 1'b1;
    step();
    idle();
    bus.rd_sel_a = 3'd1; bus.rd_sel_b = 3'd6;
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'hAA || bus.sp !== 8'hFF || bus.sp_err !== 1'b1)
      $display("FAIL mid_pre_state: got r1=%h sp=%h err=%b want AA FF 1", bus.rd_a, bus.sp, bus.sp_err);
    else pass_cnt++;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd1; bus.wr_data = 8'h55;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'h00) $display("FAIL mid_r1_async: got %h want 00", bus.rd_a);
    else pass_cnt++;
    total_cnt++;
    if (bus.rd_b !== 8'h00) $display("FAIL mid_r6_async: got %h want 00", bus.rd_b);
    else pass_cnt++;
    total_cnt++;
    if (bus.sp !== 8'hFF) $display("FAIL mid_sp_async: got %h want FF", bus.sp);
    else pass_cnt++;
    total_cnt++;
    if (bus.sp_err !== 1'b0) $display("FAIL mid_err_async: got %b want 0", bus.sp_err);
    else pass_cnt++;
    step();
    idle();
    #1 rst_n = 1'b1;
    #1;
    total_cnt++;
    if (bus.rd_a !== 8'h00) $display("FAIL mid_no_write_kept: got %h want 00", bus.rd_a);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    bus.rd_sel_a = 3'd0;
    bus.rd_sel_b = 3'd0;
    idle();
    test_reset();
    test_write_read_all();
    test_bypass();
    test_sp_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
